dir_pulse_gen: RTL and testbench

//   Converts four raw push-button inputs into the 3-bit direction code that

---
 rtl/dir_pulse_gen.sv | 134 +++++++++++++
 tb/tb_dir_pulse_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dir_pulse_gen.sv
// Push-button front end: synchronise and debounce four keys, then emit one
// single-cycle direction code per press plus timed auto-repeat while held.
module dir_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned CNT_W           = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_right,
    input  logic       key_left,
    output logic [2:0] dir,
    output logic       dir_valid
);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    // Bit order is the priority order: 0=Up, 1=Down, 2=Right, 3=Left.
    logic [3:0]       raw;
    logic [3:0]       s1_q, s2_q;
    logic [3:0]       stable_q, prev_q, press_q;
    logic [CNT_W-1:0] dcnt_q [4];

    logic             any_press;
    logic [1:0]       press_idx;
    logic             held_lvl;

    state_t           state_q;
    logic [1:0]       held_q;
    logic [CNT_W-1:0] rcnt_q;

    assign raw = {key_left, key_right, key_down, key_up};

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            press_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            prev_q  <= stable_q;
            press_q <= stable_q & ~prev_q;
            for (int unsigned i = 0; i < 4; i++) begin
                if (s2_q[i] == stable_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DB_LAST) begin
                    stable_q[i] <= s2_q[i];
                    dcnt_q[i]   <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Lowest set bit wins; simultaneous losers are simply dropped.
    always_comb begin
        any_press = |press_q;
        press_idx = 2'd0;
        if (press_q[0])      press_idx = 2'd0;
        else if (press_q[1]) press_idx = 2'd1;
        else if (press_q[2]) press_idx = 2'd2;
        else if (press_q[3]) press_idx = 2'd3;
        held_lvl = prev_q[held_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            held_q    <= '0;
            rcnt_q    <= '0;
            dir       <= '0;
            dir_valid <= 1'b0;
        end else begin
            dir       <= '0;
            dir_valid <= 1'b0;
            if (any_press) begin
                dir       <= {1'b0, press_idx} + 3'd1;
                dir_valid <= 1'b1;
                held_q    <= press_idx;
                rcnt_q    <= '0;
                state_q   <= (REPEAT_DELAY > 0) ? S_DELAY : S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_DELAY: begin
                        if (!held_lvl) begin
                            state_q <= S_IDLE;
                        end else if (rcnt_q == RD_LAST) begin
                            dir       <= {1'b0, held_q} + 3'd1;
                            dir_valid <= 1'b1;
                            rcnt_q    <= '0;
                            state_q   <= S_REPEAT;
                        end else begin
                            rcnt_q <= rcnt_q + CNT_ONE;
                        end
                    end
                    S_REPEAT: begin
                        if (!held_lvl) begin
                            state_q <= S_IDLE;
                        end else if (rcnt_q == RP_LAST) begin
                            dir       <= {1'b0, held_q} + 3'd1;
                            dir_valid <= 1'b1;
                            rcnt_q    <= '0;
                        end else begin
                            rcnt_q <= rcnt_q + CNT_ONE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dir_pulse_gen.sv
// Randomised and directed key stimulus; expected pulses are scheduled by an
// edge-indexed reference model and checked every cycle by a separate monitor.
module tb_dir_pulse_gen;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_up, key_down, key_right, key_left;
    logic [2:0] dir;
    logic       dir_valid;

    always #5 clk = ~clk;

    dir_pulse_gen #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_up   (key_up),
        .key_down (key_down),
        .key_right(key_right),
        .key_left (key_left),
        .dir      (dir),
        .dir_valid(dir_valid)
    );

    typedef struct {
        int         at;
        logic [2:0] code;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ecyc        = 0;
    int   last_edge   = -1;

    // Reference model state: raw level history, debounced level history,
    // debounce run length, and the absolute edge of the next repeat pulse.
    bit r1[4], r2[4];
    bit st[4], st1[4], st2[4];
    int unsigned cnt[4];
    int held = -1;
    int next_fire = 0;

    always @(posedge clk) begin
        bit         rawk[4];
        int         n;
        int         win;
        logic [2:0] e;
        n = ecyc;
        e = 3'd0;
        rawk[0] = key_up;
        rawk[1] = key_down;
        rawk[2] = key_right;
        rawk[3] = key_left;
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                r1[k] = 0; r2[k] = 0; st[k] = 0; st1[k] = 0; st2[k] = 0; cnt[k] = 0;
            end
            held = -1;
        end else begin
            // A press reaches the output two edges after the debounced rise.
            win = -1;
            for (int k = 0; k < 4; k++)
                if (win < 0 && st1[k] && !st2[k]) win = k;
            if (win >= 0) begin
                e = 3'(win + 1);
                if (RD > 0) begin
                    held = win;
                    next_fire = n + int'(RD);
                end else begin
                    held = -1;
                end
            end else if (held >= 0) begin
                if (!st1[held]) begin
                    held = -1;
                end else if (n == next_fire) begin
                    e = 3'(held + 1);
                    next_fire = n + int'(RP);
                end
            end
            for (int k = 0; k < 4; k++) begin
                st2[k] = st1[k];
                st1[k] = st[k];
                if (r2[k] == st[k]) cnt[k] = 0;
                else if (cnt[k] == DB - 1) begin
                    st[k]  = r2[k];
                    cnt[k] = 0;
                end else cnt[k] = cnt[k] + 1;
                r2[k] = r1[k];
                r1[k] = rawk[k];
            end
        end
        if (e != 3'd0) sbq.push_back('{at: n, code: e});
        last_edge = n;
        ecyc = ecyc + 1;
    end

    always @(negedge clk) begin
        logic [2:0] want;
        if (last_edge >= 0) begin
            want = 3'd0;
            if (sbq.size() > 0 && sbq[0].at == last_edge) want = sbq.pop_front().code;
            vectors++;
            if (dir !== want || dir_valid !== (want != 3'd0)) begin
                miscompares++;
                $display("FAIL dir@edge%0d: got dir=%b valid=%b, expected dir=%b valid=%b",
                         last_edge, dir, dir_valid, want, (want != 3'd0));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic keys(input logic [3:0] k);
        {key_left, key_right, key_down, key_up} = k;
    endtask

    initial begin
        logic [3:0] tgt;
        int         len;
        reset = 1'b1;
        keys(4'b0000);
        step(3);
        reset = 1'b0;
        step(5);

        keys(4'b0100); step(10); keys(4'b0000); step(15);

        for (int r = 0; r < 3; r++) begin
            keys(4'b0001); step(2);
            keys(4'b0000); step(1);
            keys(4'b0001); step(3);
            keys(4'b0000); step(1);
        end
        keys(4'b0001); step(15); keys(4'b0000); step(10);

        keys(4'b0010); step(60); keys(4'b0000); step(40);

        keys(4'b1001); step(50); keys(4'b0000); step(20);

        keys(4'b1000); step(15);
        reset = 1'b1; step(3);
        reset = 1'b0; step(30);
        keys(4'b0000); step(10);

        keys(4'b0100); step(45);
        keys(4'b0110); step(50);
        keys(4'b0000); step(20);

        for (int r = 0; r < 50; r++) begin
            tgt = 4'($urandom);
            len = int'($urandom_range(1, 60));
            for (int c = 0; c < len; c++) begin
                keys(($urandom_range(0, 9) == 0) ? (tgt ^ 4'($urandom)) : tgt);
                if ($urandom_range(0, 299) == 0) reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
        end
        keys(4'b0000);
        step(30);

        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending pulses, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
